load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the single-cycle core's execute/ALU path. It consumes LOAD/STORE requests: effective address = ALU result (rs1 + imm), store data = rs2_data, funct3, rd.
- Drives a word-wide data-memory port with a valid/ready request and a response-valid return.
- Returns sign- or zero-extended load data plus the rd tag, for the write-data mux.
- Handles one transaction at a time.

Parameters:
- ADDR_WIDTH, 32: width of req_addr and mem_addr.
- TIMEOUT_CYCLES, 0: maximum cycles in WAIT before aborting with error; 0 disables the timeout.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_is_store  input  1  1 = STORE opcode, 0 = LOAD opcode.
- req_funct3  input  3  instruction funct3.
- req_addr  input  ADDR_WIDTH  effective byte address.
- req_wdata  input  32  rs2_data.
- req_rd  input  5  destination register tag.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  extended load data; 0 for stores.
- resp_rd  output  5  captured rd; 0 for stores.
- resp_err  output  1  illegal funct3, misaligned access, or timeout.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_WIDTH  word address; bits [1:0] always 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_wstrb  output  4  byte strobes; 0 for loads.
- mem_rsp_valid  input  1  read data valid (loads only).
- mem_rdata  input  32  read word.

Behaviour:
- Reset (synchronous): next edge forces IDLE. All outputs 0 except req_ready, which is 1 in IDLE. Captured registers are cleared.
- Reset mid-operation: any in-flight memory transaction is abandoned. mem_rsp_valid arriving later is ignored.
- State machine: IDLE, MEM, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, capture all req_* fields.
  - Illegal funct3 → RESP with err = 1, no memory access. Loads: legal funct3 are 000, 001, 010, 100, 101. Stores: legal funct3 are 000, 001, 010.
  - Otherwise → MEM.
- MEM: mem_req_valid = 1. mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_req_ready.
  - On mem_req_ready, a store goes to RESP.
  - On mem_req_ready, a load goes to WAIT.
- WAIT: on mem_rsp_valid, capture the extended data and go to RESP.
  - If TIMEOUT_CYCLES > 0 and the cycle counter reaches TIMEOUT_CYCLES with no response, go to RESP with err = 1 and data = 0.
  - The counter clears on entering WAIT.
- RESP: resp_valid = 1, outputs held stable until resp_ready, then return to IDLE.
  - req_ready = 0 in every state except IDLE. There is no same-cycle turnaround.
- Minimum latency (accept at cycle 0, zero-wait memory):
  - mem_req_valid at cycle 1.
  - Store: resp_valid at cycle 2.
  - Load: mem_rsp_valid at cycle 2, resp_valid at cycle 3.
- mem_rsp_valid is ignored outside WAIT.
- Store lane formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{d[15:0]}}, wstrb = 4'b0011 << {addr[1], 1'b0}.
  - SW: wdata = d, wstrb = 4'b1111.
- Load extraction (shift = mem_rdata >> (8 × addr[1:0])):
  - LB / LBU: sign- / zero-extend shift[7:0].
  - LH / LHU: sign- / zero-extend the half selected by addr[1].
  - LW: full word.
- mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are halfword with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - In IDLE they go to RESP with resp_err = 1, no memory access, resp_data = 0.
- Undefined:
  - Misaligned accesses are not detected. The address is truncated to natural alignment: halfword ignores addr[0], word ignores addr[1:0].
  - Lane selection and strobes use the truncated address.
  - resp_err is driven only by illegal funct3 or timeout.

Test Plan:
- Reset, then SW addr 0x104, data 0xDEADBEEF, mem_req_ready = 1 → mem_addr 0x104, wstrb 4'b1111, wdata 0xDEADBEEF; resp_valid on cycle 2 with err 0.
- SB addr 0x203, data 0x000000A5 → wdata 0xA5A5A5A5, wstrb 4'b1000.
- LB addr 0x101, mem_rdata 0x1234F678, rsp one cycle after grant → resp_data 0xFFFFFFF6, resp_rd equals req_rd, resp_valid on cycle 3. Same access as LBU → 0x000000F6.
- LH addr 0x102, mem_req_ready held low for 3 cycles, resp_ready low for 2 cycles → request fields stable while stalled, req_ready 0 throughout, resp_data 0x00001234.
- req_funct3 = 3'b011 load → resp_err 1, mem_req_valid never asserted. With LSU_MISALIGN_TRAP_EN, LW addr 0x102 → err 1, no memory access. Without the macro, the same LW reads 0x100.
- TIMEOUT_CYCLES = 4, load with no mem_rsp_valid → resp_err 1 after 4 WAIT cycles. Assert reset during MEM → IDLE next edge, all outputs 0, req_ready 1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one LOAD/STORE at a time onto a word-wide data memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating the address.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {StIdle, StMem, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [4:0]            rd_q;
    logic [31:0]           data_q;
    logic                  err_q;
    logic [31:0]           cnt_q;

    logic                  req_legal;
    logic                  req_misaligned;
    logic                  accept_err;
    logic                  timeout_hit;
    logic [31:0]           lane_wdata;
    logic [3:0]            lane_wstrb;
    logic [31:0]           load_shift;
    logic [15:0]           load_half;
    logic [31:0]           load_ext;

    // Request decode, evaluated on the incoming fields while idle.
    always_comb begin
        if (req_is_store) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_misaligned = 1'b0;
`endif
        accept_err = !req_legal || req_misaligned;
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

    // Store lane replication and strobes; halfword strobes ignore addr[0].
    always_comb begin
        lane_wdata = wdata_q;
        lane_wstrb = 4'b1111;
        unique case (funct3_q[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_q[7:0]}};
                lane_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata_q[15:0]}};
                lane_wstrb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                lane_wdata = wdata_q;
                lane_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        load_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        load_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b100:  load_ext = {24'h0, load_shift[7:0]};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = accept_err ? StResp : StMem;
            end
            StMem: begin
                if (mem_req_ready) state_d = is_store_q ? StResp : StWait;
            end
            StWait: begin
                if (mem_rsp_valid || timeout_hit) state_d = StResp;
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            rd_q       <= 5'h0;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= 32'h0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        is_store_q <= req_is_store;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        data_q     <= 32'h0;
                        err_q      <= accept_err;
                    end
                end
                StMem: begin
                    if (mem_req_ready && !is_store_q) cnt_q <= 32'h0;
                end
                StWait: begin
                    if (mem_rsp_valid) begin
                        data_q <= load_ext;
                    end else begin
                        cnt_q <= cnt_q + 32'h1;
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced to zero outside the state that owns them.
    always_comb begin
        req_ready     = (state_q == StIdle);
        mem_req_valid = (state_q == StMem);
        mem_we        = (state_q == StMem) && is_store_q;
        mem_addr      = (state_q == StMem) ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_wdata     = mem_we ? lane_wdata : 32'h0;
        mem_wstrb     = mem_we ? lane_wstrb : 4'h0;
        resp_valid    = (state_q == StResp);
        resp_data     = resp_valid ? data_q : 32'h0;
        resp_rd       = (resp_valid && !is_store_q) ? rd_q : 5'h0;
        resp_err      = resp_valid && err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks = 0;
    int errors = 0;

    // Observations captured by drive_txn.
    int          obs_mem_n, obs_mem_cycle, obs_resp_cycle, obs_unstable, obs_busy_ready;
    logic        obs_we, obs_err, obs_ready_after, obs_valid_after, obs_timeout;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic [3:0]  obs_wstrb;
    logic [4:0]  obs_rd;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_legal(input logic st, input logic [2:0] f3);
        int v = int'(f3);
        if (st) return v <= 2;
        return (v <= 2) || (v == 4) || (v == 5);
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic logic m_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(a % 4) % m_size(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Byte offset in the word after truncating to natural alignment.
    function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
        int o = int'(a % 4);
        return o - (o % m_size(f3));
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int     n = m_size(f3);
        longint v = longint'(rd) >> (8 * m_off(f3, a));
        if (n < 4) begin
            v = v % (64'd1 << (8 * n));
            if (int'(f3) < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s = 4'h0;
        for (int i = 0; i < 4; i++)
            s[i] = (i >= m_off(f3, a)) && (i < m_off(f3, a) + m_size(f3));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % m_size(f3)) +: 8];
        return w;
    endfunction

    // ---------------- transaction driver (no checking) ----------------
    task automatic drive_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d, input logic [4:0] rd,
                             input logic [31:0] rdata, input int gnt_stall,
                             input int rsp_delay, input int rr_stall, input logic noise);
        int   cyc = 0, grant_cyc = 0, resp_n = 0;
        logic granted = 1'b0, rsp_done = 1'b0, done = 1'b0;
        obs_mem_n = 0; obs_mem_cycle = -1; obs_resp_cycle = -1;
        obs_unstable = 0; obs_busy_ready = 0; obs_timeout = 1'b0;
        obs_we = 1'b0; obs_addr = 0; obs_wdata = 0; obs_wstrb = 0;
        obs_data = 0; obs_rd = 0; obs_err = 1'b0;
        req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d; req_rd = rd;
        req_valid = 1'b1; mem_req_ready = 1'b0; resp_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rdata = rdata;
        while (!done && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            req_valid = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata = rdata;
            if (granted && !st && !rsp_done && rsp_delay >= 0 &&
                cyc == grant_cyc + 1 + rsp_delay) begin
                mem_rsp_valid = 1'b1;
                rsp_done = 1'b1;
            end else if (noise && (!granted || st || rsp_done)) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = ~rdata;
            end
            if (req_ready) obs_busy_ready++;
            if (mem_req_valid) begin
                if (obs_mem_n == 0) begin
                    obs_mem_cycle = cyc; obs_addr = mem_addr; obs_we = mem_we;
                    obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
                end else if (mem_addr !== obs_addr || mem_we !== obs_we ||
                             mem_wdata !== obs_wdata || mem_wstrb !== obs_wstrb) begin
                    obs_unstable++;
                end
                obs_mem_n++;
                mem_req_ready = (obs_mem_n > gnt_stall);
                if (mem_req_ready && !granted) begin
                    granted = 1'b1; grant_cyc = cyc;
                end
            end else begin
                mem_req_ready = 1'b0;
            end
            if (resp_valid) begin
                if (resp_n == 0) begin
                    obs_resp_cycle = cyc; obs_data = resp_data; obs_rd = resp_rd;
                    obs_err = resp_err;
                end else if (resp_data !== obs_data || resp_rd !== obs_rd ||
                             resp_err !== obs_err) begin
                    obs_unstable++;
                end
                resp_n++;
                resp_ready = (resp_n > rr_stall);
                if (resp_ready) done = 1'b1;
            end else begin
                resp_ready = 1'b0;
            end
        end
        obs_timeout = !done;
        @(posedge clk); #1;
        resp_ready = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        obs_ready_after = req_ready;
        obs_valid_after = resp_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_data, resp_rd, resp_err, mem_req_valid, mem_we, mem_addr,
             mem_wdata, mem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rv=%b rd=%h rr=%h re=%b mv=%b we=%b ma=%h md=%h ms=%h exp 0",
                     resp_valid, resp_data, resp_rd, resp_err, mem_req_valid, mem_we,
                     mem_addr, mem_wdata, mem_wstrb);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        drive_txn(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd3, 32'h0, 0, 0, 0, 1'b0);
        checks++;
        if ({obs_addr, obs_wstrb, obs_wdata, obs_we} !== {32'h104, 4'hF, 32'hDEADBEEF, 1'b1}) begin
            errors++;
            $display("FAIL sw_mem got a=%h s=%h d=%h we=%b exp a=104 s=f d=deadbeef we=1",
                     obs_addr, obs_wstrb, obs_wdata, obs_we);
        end
        checks++;
        if (obs_mem_cycle !== 1 || obs_resp_cycle !== 2 || obs_err !== 1'b0) begin
            errors++;
            $display("FAIL sw_timing got mem=%0d resp=%0d err=%b exp mem=1 resp=2 err=0",
                     obs_mem_cycle, obs_resp_cycle, obs_err);
        end
        checks++;
        if (obs_data !== 32'h0 || obs_rd !== 5'h0 || obs_ready_after !== 1'b1) begin
            errors++;
            $display("FAIL sw_resp got d=%h rd=%h ready=%b exp d=0 rd=0 ready=1",
                     obs_data, obs_rd, obs_ready_after);
        end
    endtask

    task automatic test_store_byte();
        drive_txn(1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd7, 32'h0, 0, 0, 0, 1'b0);
        checks++;
        if ({obs_addr, obs_wstrb, obs_wdata} !== {32'h200, 4'b1000, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL sb_mem got a=%h s=%b d=%h exp a=200 s=1000 d=a5a5a5a5",
                     obs_addr, obs_wstrb, obs_wdata);
        end
    endtask

    task automatic test_load_byte();
        drive_txn(1'b0, 3'b000, 32'h101, 32'h0, 5'd9, 32'h1234F678, 0, 0, 0, 1'b0);
        checks++;
        if (obs_data !== 32'hFFFFFFF6 || obs_rd !== 5'd9 || obs_resp_cycle !== 3) begin
            errors++;
            $display("FAIL lb got d=%h rd=%0d cyc=%0d exp d=fffffff6 rd=9 cyc=3",
                     obs_data, obs_rd, obs_resp_cycle);
        end
        checks++;
        if (obs_wstrb !== 4'h0 || obs_we !== 1'b0 || obs_addr !== 32'h100) begin
            errors++;
            $display("FAIL lb_mem got s=%h we=%b a=%h exp s=0 we=0 a=100",
                     obs_wstrb, obs_we, obs_addr);
        end
        drive_txn(1'b0, 3'b100, 32'h101, 32'h0, 5'd9, 32'h1234F678, 0, 0, 0, 1'b0);
        checks++;
        if (obs_data !== 32'h000000F6) begin
            errors++; $display("FAIL lbu got %h exp 000000f6", obs_data);
        end
    endtask

    task automatic test_stall();
        drive_txn(1'b0, 3'b001, 32'h102, 32'h0, 5'd12, 32'h1234F678, 3, 0, 2, 1'b0);
        checks++;
        if (obs_data !== 32'h00001234 || obs_mem_n !== 4 || obs_resp_cycle !== 6) begin
            errors++;
            $display("FAIL lh_stall got d=%h memcyc=%0d resp=%0d exp d=00001234 memcyc=4 resp=6",
                     obs_data, obs_mem_n, obs_resp_cycle);
        end
        checks++;
        if (obs_unstable !== 0 || obs_busy_ready !== 0) begin
            errors++;
            $display("FAIL lh_stable got unstable=%0d busy_ready=%0d exp 0 0",
                     obs_unstable, obs_busy_ready);
        end
    endtask

    task automatic test_illegal();
        drive_txn(1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h55555555, 0, 0, 0, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_mem_n !== 0 || obs_resp_cycle !== 1 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL illegal_load got err=%b mem=%0d cyc=%0d d=%h exp err=1 mem=0 cyc=1 d=0",
                     obs_err, obs_mem_n, obs_resp_cycle, obs_data);
        end
        drive_txn(1'b1, 3'b100, 32'h100, 32'h1, 5'd4, 32'h0, 0, 0, 0, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_mem_n !== 0) begin
            errors++;
            $display("FAIL illegal_store got err=%b mem=%0d exp err=1 mem=0", obs_err, obs_mem_n);
        end
    endtask

    task automatic test_misalign();
        drive_txn(1'b0, 3'b010, 32'h102, 32'h0, 5'd5, 32'hCAFEF00D, 0, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (obs_err !== 1'b1 || obs_mem_n !== 0 || obs_data !== 32'h0) begin
            errors++;
            $display("FAIL lw_misalign got err=%b mem=%0d d=%h exp err=1 mem=0 d=0",
                     obs_err, obs_mem_n, obs_data);
        end
`else
        checks++;
        if (obs_err !== 1'b0 || obs_addr !== 32'h100 || obs_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lw_truncate got err=%b a=%h d=%h exp err=0 a=100 d=cafef00d",
                     obs_err, obs_addr, obs_data);
        end
`endif
    endtask

    task automatic test_timeout();
        drive_txn(1'b0, 3'b010, 32'h300, 32'h0, 5'd17, 32'h12345678, 0, -1, 0, 1'b0);
        checks++;
        if (obs_err !== 1'b1 || obs_data !== 32'h0 || obs_resp_cycle !== 2 + TO ||
            obs_rd !== 5'd17) begin
            errors++;
            $display("FAIL timeout got err=%b d=%h cyc=%0d rd=%0d exp err=1 d=0 cyc=%0d rd=17",
                     obs_err, obs_data, obs_resp_cycle, obs_rd, 2 + TO);
        end
    endtask

    task automatic test_reset_mid();
        req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'h1;
        req_rd = 5'd1; req_valid = 1'b1; mem_req_ready = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++; $display("FAIL mid_mem_valid got %b exp 1", mem_req_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || {resp_valid, resp_err, mem_req_valid, mem_we, mem_addr,
                                   mem_wdata, mem_wstrb, resp_data, resp_rd} !== '0) begin
            errors++;
            $display("FAIL mid_reset got ready=%b mv=%b ma=%h ms=%h rv=%b exp ready=1 rest 0",
                     req_ready, mem_req_valid, mem_addr, mem_wstrb, resp_valid);
        end
        mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_rsp got ready=%b rv=%b exp ready=1 rv=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic        st, err;
            logic [2:0]  f3;
            logic [31:0] a, d, rdata, e_data;
            logic [4:0]  rd;
            int          gs, rsd, rrs, e_cyc;
            logic        noise;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; d = $urandom; rdata = $urandom; rd = 5'($urandom);
            gs = $urandom_range(0, 2); rsd = $urandom_range(0, 2); rrs = $urandom_range(0, 2);
            noise = 1'($urandom_range(0, 1));
            drive_txn(st, f3, a, d, rd, rdata, gs, rsd, rrs, noise);
            err = !m_legal(st, f3) || m_misaligned(f3, a);
            e_data = (err || st) ? 32'h0 : m_load(f3, a, rdata);
            e_cyc = err ? 1 : (st ? 2 + gs : 3 + gs + rsd);
            checks++;
            if (obs_err !== err || obs_data !== e_data || obs_rd !== (st ? 5'h0 : rd) ||
                obs_resp_cycle !== e_cyc) begin
                errors++;
                $display("FAIL rand_resp[%0d] st=%b f3=%0d a=%h got err=%b d=%h rd=%0d cyc=%0d exp err=%b d=%h rd=%0d cyc=%0d",
                         n, st, f3, a, obs_err, obs_data, obs_rd, obs_resp_cycle, err, e_data,
                         st ? 5'h0 : rd, e_cyc);
            end
            checks++;
            if (obs_mem_n !== (err ? 0 : gs + 1) ||
                (!err && (obs_addr !== (a & 32'hFFFFFFFC) || obs_we !== st ||
                          obs_wstrb !== (st ? m_strb(f3, a) : 4'h0) ||
                          (st && obs_wdata !== m_wdata(f3, d))))) begin
                errors++;
                $display("FAIL rand_mem[%0d] st=%b f3=%0d a=%h got n=%0d ma=%h we=%b s=%h wd=%h exp n=%0d ma=%h s=%h wd=%h",
                         n, st, f3, a, obs_mem_n, obs_addr, obs_we, obs_wstrb, obs_wdata,
                         err ? 0 : gs + 1, a & 32'hFFFFFFFC, st ? m_strb(f3, a) : 4'h0,
                         m_wdata(f3, d));
            end
            checks++;
            if (obs_unstable !== 0 || obs_busy_ready !== 0 || obs_timeout !== 1'b0 ||
                obs_ready_after !== 1'b1 || obs_valid_after !== 1'b0) begin
                errors++;
                $display("FAIL rand_hs[%0d] got unstable=%0d busy_ready=%0d hang=%b ready=%b rv=%b exp 0 0 0 1 0",
                         n, obs_unstable, obs_busy_ready, obs_timeout, obs_ready_after,
                         obs_valid_after);
            end
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0; resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte();
        test_stall();
        test_illegal();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
